// File: rtl/vswitch_output_arbiter.sv
// ---------------------------------------------------------------------------
// vswitch_output_arbiter
//
// Purpose:
//   Merges the AXI4-Stream outputs of NUM_INPUTS virtual switches into one
//   stream. Every input has its own fall-through FIFO. Whole packets are
//   granted one at a time, either round-robin (ARB_MODE=0) or by strict
//   priority with the lowest index winning (ARB_MODE=1). The block also keeps
//   a forwarded-packet counter for each input.
//
// Ports:
//   axis_aclk, axis_resetn      clock, synchronous active-low reset
//   s_axis_t*                   per-input slave streams, input i in slice i
//   s_axis_tready               per-input ready, low when the FIFO is nearly full
//   m_axis_t*                   merged master stream
//   cnt_clear                   synchronous pulse that clears all counters
//   pkt_cnt                     packets forwarded per input, input i in slice i
//   grant                       index of the input being served or last served
//   pkt_fwd                     pulse on the first transferred word of a packet
// ---------------------------------------------------------------------------
module vswitch_output_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 304,
  parameter int NUM_INPUTS         = 5,
  parameter int FIFO_DEPTH_BITS    = 6,
  parameter int ARB_MODE           = 0,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                                              axis_aclk,
  input  logic                                              axis_resetn,
  input  logic [NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [NUM_INPUTS*(C_AXIS_DATA_WIDTH/8)-1:0]       s_axis_tkeep,
  input  logic [NUM_INPUTS*C_AXIS_TUSER_WIDTH-1:0]          s_axis_tuser,
  input  logic [NUM_INPUTS-1:0]                             s_axis_tvalid,
  input  logic [NUM_INPUTS-1:0]                             s_axis_tlast,
  output logic [NUM_INPUTS-1:0]                             s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]                    m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]                     m_axis_tuser,
  output logic                                              m_axis_tvalid,
  output logic                                              m_axis_tlast,
  input  logic                                              m_axis_tready,
  input  logic                                              cnt_clear,
  output logic [NUM_INPUTS*CNT_WIDTH-1:0]                   pkt_cnt,
  output logic [$clog2(NUM_INPUTS)-1:0]                     grant,
  output logic                                              pkt_fwd
);

  localparam int KEEP_WIDTH  = C_AXIS_DATA_WIDTH / 8;
  localparam int GRANT_WIDTH = $clog2(NUM_INPUTS);
  localparam int DEPTH       = 1 << FIFO_DEPTH_BITS;
  localparam int ENTRY_WIDTH = C_AXIS_TUSER_WIDTH + KEEP_WIDTH + C_AXIS_DATA_WIDTH + 1;
  localparam logic [FIFO_DEPTH_BITS:0] NEARLY_FULL_LEVEL = (FIFO_DEPTH_BITS+1)'(DEPTH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [GRANT_WIDTH-1:0]  grant_next;
  logic [GRANT_WIDTH-1:0]  sel;
  logic [GRANT_WIDTH-1:0]  rr_idx;
  logic                    first_beat;
  logic                    xfer;
  logic [ENTRY_WIDTH-1:0]  sel_entry;

  logic [NUM_INPUTS-1:0]   wr_en;
  logic [NUM_INPUTS-1:0]   rd_en;
  logic [NUM_INPUTS-1:0]   empty;
  logic [NUM_INPUTS-1:0]   nearly_full;
  logic [ENTRY_WIDTH-1:0]  head [NUM_INPUTS];

  assign s_axis_tready = ~nearly_full;

  // Per-input fall-through FIFO. Ready is withdrawn while at most one entry
  // is free, so a word arriving in the same cycle as the ready drop still fits.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_fifo
    logic [ENTRY_WIDTH-1:0]     mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   count;

    assign wr_en[i]       = s_axis_tvalid[i] & ~nearly_full[i];
    assign rd_en[i]       = xfer && (grant == GRANT_WIDTH'(i));
    assign empty[i]       = (count == '0);
    assign nearly_full[i] = (count >= NEARLY_FULL_LEVEL);
    assign head[i]        = mem[rd_ptr];

    // Storage array; contents are never reset, the pointers define validity.
    always_ff @(posedge axis_aclk) begin
      if (wr_en[i]) begin
        mem[wr_ptr] <= {s_axis_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH],
                        s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH],
                        s_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH],
                        s_axis_tlast[i]};
      end
    end

    // Pointer and occupancy tracking; reset flushes the FIFO.
    always_ff @(posedge axis_aclk) begin
      if (!axis_resetn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en[i]) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en[i]) rd_ptr <= rd_ptr + 1'b1;
        case ({wr_en[i], rd_en[i]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Winner selection. Round-robin scans downward from grant+NUM_INPUTS to
  // grant+1 so the last hit is the closest input after the previous grant.
  always_comb begin
    sel    = grant;
    rr_idx = '0;
    if (ARB_MODE == 1) begin
      for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
        if (!empty[GRANT_WIDTH'(i)]) sel = GRANT_WIDTH'(i);
      end
    end else begin
      for (int k = NUM_INPUTS; k >= 1; k--) begin
        rr_idx = GRANT_WIDTH'((int'(grant) + k) % NUM_INPUTS);
        if (!empty[rr_idx]) sel = rr_idx;
      end
    end
  end

  // State register. first_beat is re-armed in every IDLE cycle and cleared by
  // the first transfer, which is what pkt_fwd keys off.
  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state      <= IDLE;
      grant      <= GRANT_WIDTH'(NUM_INPUTS - 1);
      first_beat <= 1'b0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      if (state == IDLE) begin
        first_beat <= 1'b1;
      end else if (xfer) begin
        first_beat <= 1'b0;
      end
    end
  end

  // Next-state logic. SEND is left only on a transfer carrying tlast, so an
  // underrun mid-packet simply waits on the same input.
  always_comb begin
    state_next = state;
    grant_next = grant;
    case (state)
      IDLE: begin
        if (|(~empty)) begin
          state_next = SEND;
          grant_next = sel;
        end
      end
      SEND: begin
        if (xfer && m_axis_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic. The data path always shows the head of the granted FIFO,
  // which cannot change while the word is stalled because only a transfer pops.
  always_comb begin
    sel_entry = head[grant];
    {m_axis_tuser, m_axis_tkeep, m_axis_tdata, m_axis_tlast} = sel_entry;
    m_axis_tvalid = (state == SEND) && !empty[grant];
    xfer          = m_axis_tvalid && m_axis_tready;
    pkt_fwd       = xfer && first_beat;
  end

  // Packet counters. A clear in the same cycle as an increment still keeps
  // that one packet.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt;
    logic                 incr;

    assign incr = xfer && m_axis_tlast && (grant == GRANT_WIDTH'(i));
    assign pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt;

    always_ff @(posedge axis_aclk) begin
      if (!axis_resetn) begin
        cnt <= '0;
      end else if (incr) begin
        cnt <= (cnt_clear ? '0 : cnt) + CNT_WIDTH'(1);
      end else if (cnt_clear) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: doc/vswitch_output_arbiter.md
Name: vswitch_output_arbiter

Overview:
- Parametrised N-input packet arbiter that merges the AXI4-Stream outputs of the virtual P4 switches into one stream toward the output queues.
- Each input is buffered in its own fall-through FIFO, so no words are lost while other inputs are being served.
- Arbitration is selectable: round-robin or strict priority. Grants are per packet; packets are never interleaved.
- Provides per-input forwarded-packet counters and a grant indicator.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width (tkeep = C_AXIS_DATA_WIDTH/8).
- C_AXIS_TUSER_WIDTH, 304, tuser width.
- NUM_INPUTS, 5, number of slave streams (2..16).
- FIFO_DEPTH_BITS, 6, log2 of words per input FIFO.
- ARB_MODE, 0, arbitration mode: 0 = round-robin, 1 = strict priority (lowest index wins).
- CNT_WIDTH, 32, width of each packet counter.

Ports:
- axis_aclk  in  1  clock.
- axis_resetn  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  NUM_INPUTS*C_AXIS_DATA_WIDTH  input i occupies slice i.
- s_axis_tkeep  in  NUM_INPUTS*C_AXIS_DATA_WIDTH/8  per-input tkeep.
- s_axis_tuser  in  NUM_INPUTS*C_AXIS_TUSER_WIDTH  per-input tuser.
- s_axis_tvalid  in  NUM_INPUTS  per-input valid.
- s_axis_tlast  in  NUM_INPUTS  per-input last.
- s_axis_tready  out  NUM_INPUTS  per-input ready.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  merged data.
- m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8  merged keep.
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  merged user.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tlast  out  1  merged last.
- m_axis_tready  in  1  downstream ready.
- cnt_clear  in  1  synchronous pulse; clears all packet counters.
- pkt_cnt  out  NUM_INPUTS*CNT_WIDTH  packets forwarded per input.
- grant  out  log2(NUM_INPUTS)  index of the input currently or last served.
- pkt_fwd  out  1  one-cycle pulse on the first word of each forwarded packet.

Behaviour:
- Reset (axis_resetn=0 at a clock edge):
  - FIFOs flushed; state=IDLE; grant=NUM_INPUTS-1, so the first round-robin winner is input 0.
  - pkt_cnt=0, pkt_fwd=0, m_axis_tvalid=0.
  - A reset asserted mid-packet discards the remainder of that packet; the output never resumes a partial packet.
- Input side:
  - s_axis_tready[i] = !nearly_full[i], where nearly_full means at most 1 free entry.
  - A write occurs on tvalid & tready. tvalid while tready=0 is ignored; the upstream must hold the word.
- Arbiter FSM, states IDLE and SEND:
  - IDLE: m_axis_tvalid=0. If any FIFO is non-empty, choose a winner, register it into grant, and go to SEND. Otherwise stay in IDLE with grant unchanged.
    - Round-robin: the first non-empty input searching from grant+1 upward, wrapping NUM_INPUTS-1 -> 0.
    - Strict priority: the lowest-index non-empty input.
  - SEND: m_axis_* = head of FIFO[grant]; m_axis_tvalid = !empty[grant].
    - A word transfers on m_axis_tvalid & m_axis_tready, which pops FIFO[grant].
    - pkt_fwd pulses in the cycle of the first transfer of the packet.
    - A transfer with tlast=1 increments pkt_cnt[grant] and returns the FSM to IDLE.
  - Underrun mid-packet (FIFO[grant] empties before tlast): stay in SEND with tvalid=0 until data arrives. Never switch inputs mid-packet.
- Timing:
  - One bubble cycle in IDLE between packets.
  - Minimum latency from input write to m_axis_tvalid is 2 cycles: the FIFO write cycle, then the IDLE selection cycle.
  - Outputs are stable while tvalid=1 and tready=0 (AXI-S rule).
- Counters:
  - Wrap modulo 2^CNT_WIDTH.
  - cnt_clear coincident with an increment gives 0 for all inputs except the incremented one, which becomes 1.
- Fairness: in round-robin mode, with all inputs continuously backlogged, each input receives exactly one packet per NUM_INPUTS grants.

Test Plan:
- Reset, then a single 3-word packet on input 2 with m_axis_tready=1 -> tvalid rises 2 cycles after the first write; 3 beats in order, tlast on beat 3; pkt_fwd pulses once; pkt_cnt[2]=1; grant=2.
- ARB_MODE=0, inputs 0..4 each preloaded with two 1-word packets -> output order 0,1,2,3,4,0,1,2,3,4; every pkt_cnt=2.
- ARB_MODE=1, inputs 1 and 3 each backlogged with 4 packets -> all of input 1 is sent before any of input 3. Then a packet on input 0 arriving during an input-1 packet is sent immediately after that packet ends, never interrupting it.
- Backpressure: m_axis_tready toggled 1,0,0,1 during a 5-word packet while input 1 keeps writing -> output data held stable while stalled; s_axis_tready[1] drops at 2^FIFO_DEPTH_BITS-1 occupancy; no word lost or duplicated; scoreboard matches.
- Underrun: input 4 sends word 1, idles 5 cycles, then sends words 2-3 (tlast) while input 0 holds a packet -> the input 4 packet completes contiguously before input 0 is granted.
- Reset mid-packet after 2 of 4 words; cnt_clear asserted coincident with a tlast on input 3 -> after reset, tvalid=0 and all counters 0. For the cnt_clear case, pkt_cnt[3]=1 and all other counters 0.
